// File: rtl/alu_share_arb_if.sv
// -----------------------------------------------------------------------------
// alu_share_arb_if
//   Bundles every handshake and bus signal around the shared-ALU arbiter:
//   - two request channels (valid/ready, operands, opcode)
//   - the ALU drive (registered operands/opcode) and its returned result/flags
//   - one tagged response channel (valid/ready, id, result, flags, err)
//
//   Modports:
//     slave  : the arbiter (alu_share_arb) view
//     master : the surrounding environment (requesters, ALU, response sink)
// -----------------------------------------------------------------------------
interface alu_share_arb_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);
  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  // Shared ALU
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_neg;
  logic              alu_overflow;
  logic              alu_carry;
  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero, alu_neg, alu_overflow, alu_carry,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero, alu_neg, alu_overflow, alu_carry,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//   Two-requester round-robin arbiter/sequencer in front of one shared
//   combinational 32-bit ALU (add, sub, and, or, slt).
//
//   Flow: IDLE grants one request and registers its operands onto the ALU
//   inputs -> EXEC lets the ALU settle for one cycle and captures result and
//   flags -> RESP presents a tagged response until the consumer takes it.
//   Handshake at cycle N gives rsp_valid from cycle N+2.
//
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     bus (slave)         request channels, ALU drive/return, response channel
//     stat_cnt0/1         (only with ALU_SHARE_ARB_STATS_EN) saturating 16-bit
//                         counts of accepted requests per requester
//
//   Optional feature macro: ALU_SHARE_ARB_STATS_EN
// -----------------------------------------------------------------------------
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arb_if.slave    bus
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Highest legal opcode (slt); anything above is reported as an error.
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(4);

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              cur_id_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [3:0]        rsp_flags_q;
  logic              rsp_err_q;

  logic              gnt_id;
  logic              ready0, ready1;
  logic              handshake;

  // ---------------------------------------------------------------------------
  // Grant and next-state logic
  // ---------------------------------------------------------------------------
  // A lone requester always wins; on a tie the one not served last time wins.
  // When neither is valid gnt_id is don't-care because no ready is raised.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

    unique case (state_q)
      IDLE: begin
        ready0 = bus.req0_valid && !gnt_id;
        ready1 = bus.req1_valid &&  gnt_id;
        if (ready0 || ready1) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign handshake      = ready0 || ready1;
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand issue, result capture, response hold
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;   // requester 0 wins the first tie
      cur_id_q     <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // ALU inputs change only here, so they hold the last issued op
          // while idle and in RESP.
          if (handshake) begin
            alu_a_q      <= gnt_id ? bus.req1_a  : bus.req0_a;
            alu_b_q      <= gnt_id ? bus.req1_b  : bus.req0_b;
            alu_op_q     <= gnt_id ? bus.req1_op : bus.req0_op;
            cur_id_q     <= gnt_id;
            last_grant_q <= gnt_id;
          end
        end
        EXEC: begin
          rsp_id_q    <= cur_id_q;
          rsp_valid_q <= 1'b1;
          if (alu_op_q > OP_MAX) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'b1000;
            rsp_err_q    <= 1'b1;
          end else begin
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= {bus.alu_zero, bus.alu_neg, bus.alu_overflow, bus.alu_carry};
            rsp_err_q    <= 1'b0;
          end
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_SHARE_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Per-requester accepted-request counters, saturating at all-ones
  // ---------------------------------------------------------------------------
  logic [15:0] stat_cnt0_q, stat_cnt1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else begin
      if (ready0 && stat_cnt0_q != 16'hFFFF) stat_cnt0_q <= stat_cnt0_q + 16'd1;
      if (ready1 && stat_cnt1_q != 16'hFFFF) stat_cnt1_q <= stat_cnt1_q + 16'd1;
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//   Directed bench for alu_share_arb. A behavioural ALU closes the loop; the
//   stimulus pushes hand-computed expected responses into a queue and an
//   independent monitor pops and compares on every response handshake.
//   Build with +define+ALU_SHARE_ARB_STATS_EN to cover the counters.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_share_arb_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  alu_share_arb #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal opcodes return junk the arbiter must mask.
  always_comb begin
    logic [32:0] wide;
    wide             = '0;
    bus.alu_result   = '0;
    bus.alu_overflow = 1'b0;
    bus.alu_carry    = 1'b0;
    unique case (bus.alu_op)
      OP_ADD: begin
        wide             = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result   = wide[31:0];
        bus.alu_carry    = wide[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (wide[31] != bus.alu_a[31]);
      end
      OP_SUB: begin
        bus.alu_result   = bus.alu_a - bus.alu_b;
        bus.alu_carry    = (bus.alu_a >= bus.alu_b);
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (bus.alu_result[31] != bus.alu_a[31]);
      end
      OP_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      OP_SLT: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      default: begin
        bus.alu_result   = bus.alu_a ^ bus.alu_b ^ 32'hDEAD_BEEF;
        bus.alu_overflow = 1'b1;
        bus.alu_carry    = 1'b1;
      end
    endcase
    bus.alu_zero = (bus.alu_result == '0);
    bus.alu_neg  = bus.alu_result[31];
    if (bus.alu_op > OP_SLT) begin
      bus.alu_zero = 1'b0;
      bus.alu_neg  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard plumbing
  // ---------------------------------------------------------------------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d result=%h with no pending expectation (t=%0t)",
                 bus.rsp_id, bus.rsp_result, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id",     {31'd0, bus.rsp_id},     {31'd0, e.id});
        check("rsp_result", bus.rsp_result,          e.result);
        check("rsp_flags",  {28'd0, bus.rsp_flags},  {28'd0, e.flags});
        check("rsp_err",    {31'd0, bus.rsp_err},    {31'd0, e.err});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) until the given requester sees ready; returns just before
  // the handshake edge.
  task automatic wait_grant(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input exp_t e);
    bit ok;
    set_req(id, 1'b1, a, b, op);
    wait_grant(id, ok);
    check("issue_granted", {31'd0, ok}, 32'd1);
    exp_q.push_back(e);
    tick();
    set_req(id, 1'b0, a, b, op);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Both requesters held valid: n handshakes must alternate starting at first.
  task automatic serve_both(input int n, input int first, input exp_t e0, input exp_t e1);
    for (int k = 0; k < n; k++) begin
      bit ok;
      int want;
      want = first ^ (k & 1);
      ok   = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (bus.req0_ready || bus.req1_ready) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      check("pair_granted", {31'd0, ok}, 32'd1);
      check("pair_ready0", {31'd0, bus.req0_ready}, (want == 0) ? 32'd1 : 32'd0);
      check("pair_ready1", {31'd0, bus.req1_ready}, (want == 1) ? 32'd1 : 32'd0);
      exp_q.push_back((want == 0) ? e0 : e1);
      tick();
      if (k == n - 1) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e0, e1;
    bit   ok;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
    check("rst_alu_a",      bus.alu_a,               32'd0);
    check("rst_alu_b",      bus.alu_b,               32'd0);
    check("rst_alu_op",     {29'd0, bus.alu_op},     32'd0);
    check("rst_rsp_id",     {31'd0, bus.rsp_id},     32'd0);
    check("rst_rsp_result", bus.rsp_result,          32'd0);
    check("rst_rsp_flags",  {28'd0, bus.rsp_flags},  32'd0);
    check("rst_rsp_err",    {31'd0, bus.rsp_err},    32'd0);

    // Single add with signed overflow, latency N+2
    set_req(0, 1'b1, 32'h7FFF_FFFF, 32'd1, OP_ADD);
    #1;
    check("t1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("t1_ready1", {31'd0, bus.req1_ready}, 32'd0);
    exp_q.push_back('{id: 1'b0, result: 32'h8000_0000, flags: 4'b0110, err: 1'b0});
    tick();
    set_req(0, 1'b0, '0, '0, OP_ADD);
    check("t1_alu_a",     bus.alu_a,              32'h7FFF_FFFF);
    check("t1_alu_b",     bus.alu_b,              32'd1);
    check("t1_exec_vld",  {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check("t1_n2_vld",    {31'd0, bus.rsp_valid}, 32'd1);
    tick();
    check("t1_done_vld",  {31'd0, bus.rsp_valid}, 32'd0);
    check("t1_alu_hold",  bus.alu_a,              32'h7FFF_FFFF);

    // Tie after reset: req0 first, then alternate 0,1,0,1
    do_reset();
    set_req(0, 1'b1, 32'd5,  32'd5,  OP_SUB);
    set_req(1, 1'b1, 32'hF0, 32'h0F, OP_OR);
    e0 = '{id: 1'b0, result: 32'd0,  flags: 4'b1001, err: 1'b0};
    e1 = '{id: 1'b1, result: 32'hFF, flags: 4'b0000, err: 1'b0};
    serve_both(4, 0, e0, e1);
    drain();

    // Backpressure: response held, no new grant while RESP
    bus.rsp_ready = 1'b0;
    issue(0, 32'hFF00_FF00, 32'h0FF0_0FF0, OP_AND,
          '{id: 1'b0, result: 32'h0F00_0F00, flags: 4'b0000, err: 1'b0});
    set_req(1, 1'b1, 32'd1, 32'd2, OP_OR);
    tick();
    check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_result", bus.rsp_result,          32'h0F00_0F00);
      check("bp_hold_id",     {31'd0, bus.rsp_id},     32'd0);
      check("bp_hold_flags",  {28'd0, bus.rsp_flags},  32'd0);
      check("bp_hold_valid",  {31'd0, bus.rsp_valid},  32'd1);
      check("bp_ready0_low",  {31'd0, bus.req0_ready}, 32'd0);
      check("bp_ready1_low",  {31'd0, bus.req1_ready}, 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    check("bp_idle_vld",    {31'd0, bus.rsp_valid},  32'd0);
    check("bp_new_grant",   {31'd0, bus.req1_ready}, 32'd1);
    exp_q.push_back('{id: 1'b1, result: 32'd3, flags: 4'b0000, err: 1'b0});
    tick();
    set_req(1, 1'b0, '0, '0, OP_ADD);
    drain();

    // Illegal opcode from requester 1
    issue(1, 32'd1, 32'd2, 3'b110, '{id: 1'b1, result: 32'd0, flags: 4'b1000, err: 1'b1});
    drain();

    // Reset during EXEC abandons the op; requester 0 wins next tie
    set_req(1, 1'b1, 32'd1, 32'd1, OP_ADD);
    wait_grant(1, ok);
    check("rx_granted", {31'd0, ok}, 32'd1);
    tick();
    rst_n = 1'b0;
    set_req(1, 1'b0, '0, '0, OP_ADD);
    tick();
    check("rx_valid_low",  {31'd0, bus.rsp_valid}, 32'd0);
    check("rx_result_clr", bus.rsp_result,         32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rx_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    set_req(0, 1'b1, 32'd2,         32'd3, OP_ADD);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, OP_SLT);
    e0 = '{id: 1'b0, result: 32'd5, flags: 4'b0000, err: 1'b0};
    e1 = '{id: 1'b1, result: 32'd1, flags: 4'b0000, err: 1'b0};
    serve_both(2, 0, e0, e1);
    drain();

`ifdef ALU_SHARE_ARB_STATS_EN
    do_reset();
    check("st_rst0", {16'd0, stat_cnt0}, 32'd0);
    for (int i = 0; i < 3; i++)
      issue(0, 32'd4, 32'd4, OP_AND, '{id: 1'b0, result: 32'd4, flags: 4'b0000, err: 1'b0});
    for (int i = 0; i < 2; i++)
      issue(1, 32'd4, 32'd1, OP_SUB, '{id: 1'b1, result: 32'd3, flags: 4'b0001, err: 1'b0});
    drain();
    check("st_cnt0", {16'd0, stat_cnt0}, 32'd3);
    check("st_cnt1", {16'd0, stat_cnt1}, 32'd2);
    force dut.stat_cnt0_q = 16'hFFFF;
    #1;
    release dut.stat_cnt0_q;
    issue(0, 32'd0, 32'd0, OP_OR, '{id: 1'b0, result: 32'd0, flags: 4'b1000, err: 1'b0});
    drain();
    check("st_sat0", {16'd0, stat_cnt0}, 32'hFFFF);
    check("st_cnt1_keep", {16'd0, stat_cnt1}, 32'd2);
`endif

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester arbiter and sequencer for the shared 32-bit combinational ALU (ops: add, sub, and, or, set-less-than).
- Accepts operation requests over valid/ready handshakes, grants round-robin and drives the ALU from registered operands.
- Captures result and flags, then returns them on a single tagged response channel with backpressure.
- Sits between the two issuing units and the ALU instance.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU width.
- OP_W, 3, opcode width; legal opcodes 3'b000–3'b100.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid / req1_valid  input  1  request present from requester 0 / 1.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands.
- req0_op / req1_op  input  OP_W  ALU opcode.
- alu_a, alu_b  output  DATA_W  to ALU operands; driven from registered operands.
- alu_op  output  OP_W  to ALU opcode; registered.
- alu_result  input  DATA_W  from ALU.
- alu_zero, alu_neg, alu_overflow, alu_carry  input  1  ALU flags.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the op.
- rsp_result  output  DATA_W  captured result.
- rsp_flags  output  4  {zero, neg, overflow, carry}.
- rsp_err  output  1  opcode was illegal (101–111).

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; last_grant=1 (requester 0 wins first tie); alu_a=alu_b=0; alu_op=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0; rsp_err=0. Reset mid-operation abandons the op with no response.
- States IDLE, EXEC, RESP.
- IDLE:
  - Exactly one of req*_ready may be high. It is combinational: high only in IDLE, for the granted requester, and only if that requester's valid is high.
  - Grant rule: if only one valid, grant it. If both valid, grant the one != last_grant.
  - On handshake: latch a, b and op into alu_a/alu_b/alu_op; record id; last_grant<=id; go to EXEC.
- EXEC (one cycle):
  - ALU settles on the registered operands.
  - At the edge, capture rsp_result<=alu_result and rsp_flags<={zero,neg,overflow,carry}.
  - If op is illegal: rsp_result<=0, rsp_flags<=4'b1000 (zero), rsp_err<=1. Otherwise rsp_err<=0.
  - rsp_valid<=1; go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - No new request is accepted in RESP or EXEC.
- Latency: handshake at cycle N → rsp_valid high from cycle N+2. Peak throughput is one op per 3 cycles with rsp_ready tied high.
- alu_a/alu_b/alu_op hold the last issued operands outside EXEC (no toggling while idle).
- Requester dropping valid before grant: no effect; the arbiter does not remember it.
- last_grant changes only on an accepted request, never on an idle cycle.
- Flags pass through unmodified: overflow/carry are 0 for and/or/slt as the ALU produces them.

Optional Feature:
- Macro ALU_SHARE_ARB_STATS_EN.
- Defined: adds output ports stat_cnt0 and stat_cnt1, each 16 bits.
  - Each counts accepted requests from requester 0 / 1.
  - Increments on that requester's req handshake.
  - Saturates at 16'hFFFF.
  - Reset to 0 on rst_n=0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then req0 add A=32'h7FFFFFFF B=1 → rsp at +2 cycles: id=0, result=32'h80000000, flags={0,1,1,0}, err=0.
- Both valid same cycle after reset, req0 sub 5-5 and req1 or 0xF0|0x0F → req0 served first (result 0, flags={1,0,0,1}), then req1 (result 32'hFF, id=1). Keep both valid for 4 ops → grants alternate 0,1,0,1.
- rsp_ready held low 5 cycles after rsp_valid → rsp_* stable; req ready stays 0 throughout. rsp_ready=1 → IDLE next cycle, new grant the cycle after.
- req1 op=3'b110 → rsp_err=1, result=0, flags=4'b1000.
- rst_n low during EXEC → next cycle rsp_valid=0, state IDLE, requester 0 wins the next tie.
- With ALU_SHARE_ARB_STATS_EN: 3 req0 and 2 req1 ops → stat_cnt0=3, stat_cnt1=2. Force-preload stat_cnt0=16'hFFFF then issue one req0 op → stat_cnt0 stays 16'hFFFF.
